// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: shared FSM state type and sizing/clamp helpers for the joystick A/D emulator.
package adc_emu_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/axis_emu.sv
// axis_emu: one channel's switch-driven position integrator, stepped once per vblank rise.
module axis_emu
    import adc_emu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STEP   = 1,
    parameter int CENTER = 127
) (
    input  logic              clk6m,
    input  logic              reset,
    input  logic              rise,
    input  logic              dec_n,
    input  logic              inc_n,
    output logic [DATA_W-1:0] pos
);

    localparam int MAXV = (1 << DATA_W) - 1;

    logic [DATA_W-1:0] r_pos;
    int                w_p;
    int                w_next;

    // Released stick returns toward CENTER, clamped so it never overshoots.
    always_comb begin
        w_p    = int'(r_pos);
        w_next = !dec_n ? clamp(w_p - STEP, 0, MAXV) :
                 !inc_n ? clamp(w_p + STEP, 0, MAXV) :
                 (w_p > CENTER) ? clamp(w_p - STEP, CENTER, MAXV) :
                                  clamp(w_p + STEP, 0, CENTER);
    end

    always_ff @(posedge clk6m) begin
        if (reset)
            r_pos <= DATA_W'(CENTER);
        else if (rise)
            r_pos <= DATA_W'(w_next);
    end

    assign pos = r_pos;

endmodule

// File: rtl/adc_joystick_emu.sv
// adc_joystick_emu: multi-channel A/D converter emulation with analog or digital-stick sources
// and a CPU start/convert/EOC/read handshake.
module adc_joystick_emu
    import adc_emu_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 8,
    parameter int CONV_CYCLES = 8,
    parameter int STEP        = 1,
    parameter int CENTER      = 127,
    localparam int ADDR_W     = addr_w(NUM_CH)
) (
    input  logic                     clk6m,
    input  logic                     reset,
    input  logic                     vblank,
    input  logic [2*NUM_CH-1:0]      dig_n,
    input  logic [NUM_CH-1:0]        ch_emu,
    input  logic [NUM_CH*DATA_W-1:0] analog,
    input  logic [ADDR_W-1:0]        a,
    input  logic                     wr_n,
    input  logic                     rd_n,
    output logic [15:0]              data_out,
    output logic                     eoc
);

    localparam int CW = addr_w(CONV_CYCLES);

    logic              r_vb_q;
    logic              r_wr_q;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_ch;
    logic [DATA_W-1:0] r_result;
    logic              w_rise;
    logic              w_start;
    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] w_pos [NUM_CH];

    assign w_rise  = vblank & ~r_vb_q;
    assign w_start = ~wr_n & r_wr_q;
    assign w_src   = ch_emu[r_ch] ? w_pos[r_ch] : analog[r_ch*DATA_W +: DATA_W];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_axis
        axis_emu #(.DATA_W(DATA_W), .STEP(STEP), .CENTER(CENTER)) u_axis (
            .clk6m (clk6m),
            .reset (reset),
            .rise  (w_rise),
            .dec_n (dig_n[2*k]),
            .inc_n (dig_n[2*k+1]),
            .pos   (w_pos[k])
        );
    end

    // Read clears eoc first so that a completing conversion in the same cycle wins.
    always_ff @(posedge clk6m) begin
        if (reset) begin
            r_vb_q   <= 1'b0;
            r_wr_q   <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ch     <= '0;
            r_result <= '0;
            data_out <= '0;
            eoc      <= 1'b0;
        end else begin
            r_vb_q <= vblank;
            r_wr_q <= wr_n;
            if (!rd_n) begin
                data_out <= {{(16-DATA_W){1'b0}}, r_result};
                eoc      <= 1'b0;
            end
            if (w_start) begin
                r_state <= CONV;
                r_ch    <= (int'(a) >= NUM_CH) ? '0 : a;
                r_cnt   <= CW'(CONV_CYCLES - 1);
                eoc     <= 1'b0;
            end else if (r_state == CONV) begin
                if (r_cnt == '0) begin
                    r_result <= w_src;
                    eoc      <= 1'b1;
                    r_state  <= DONE;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule
